// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packer_pkg
//  Description : Shared types, default sizes and helpers for fifo_pop_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package packer_pkg;

  // Packer control states: collecting words, or presenting a finished beat.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_D_WIDTH = 6;
  localparam int DEF_PACK_N  = 4;
  localparam int DEF_TIMEOUT = 8;

  // Width needed to hold a lane count in the range 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/packer_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : packer_idle_timer
//  Description : Idle-cycle counter that flags when a partial beat has waited
//                TIMEOUT cycles. Only built when PACKER_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef PACKER_TIMEOUT_EN
module packer_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: clear wins, otherwise count up and saturate at TIMEOUT.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != TW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TW'(TIMEOUT));

endmodule
`endif
`default_nettype wire

// File: rtl/fifo_pop_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pop_packer
//  Description : Drains a first-word-fall-through FIFO and packs PACK_N words
//                into one wide beat on a valid/ready output. Partial beats
//                leave on flush, or on idle timeout when PACKER_TIMEOUT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_pop_packer
  import packer_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int PACK_N  = DEF_PACK_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [D_WIDTH-1:0]             fifo_data,
  input  logic                           fifo_empty,
  output logic                           fifo_pop,
  input  logic                           flush,
  output logic [D_WIDTH*PACK_N-1:0]      out_data,
  output logic [cnt_width(PACK_N)-1:0]   out_count,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CW = cnt_width(PACK_N);

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [CW-1:0]               count_q, count_d;
  logic [D_WIDTH*PACK_N-1:0]   data_q, data_d;
  logic [CW-1:0]               cnt_inc;
  logic                        timeout_flush;
  logic                        flush_eff;

  assign fifo_pop  = !rst && !fifo_empty && ((state_q == FILL) || out_ready);
  assign cnt_inc   = cnt_q + 1'b1;
  assign flush_eff = flush || timeout_flush;

`ifdef PACKER_TIMEOUT_EN
  logic timer_en;
  logic timer_clear;

  assign timer_en    = (state_q == FILL) && (cnt_q != '0) && !fifo_pop;
  assign timer_clear = fifo_pop || flush || (state_q != FILL);

  packer_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .count_en (timer_en),
    .expired  (timeout_flush)
  );
`else
  // No timer: TIMEOUT has no meaning here, and this term is always false.
  assign timeout_flush = (TIMEOUT < 0);
`endif

  // Next-state, lane writes and beat bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    data_d  = data_q;
    case (state_q)
      FILL: begin
        if (fifo_pop) begin
          for (int i = 0; i < PACK_N; i++) begin
            if (cnt_q == CW'(i)) begin
              data_d[i*D_WIDTH +: D_WIDTH] = fifo_data;
            end
          end
          if ((cnt_inc == CW'(PACK_N)) || flush_eff) begin
            state_d = HOLD;
            count_d = cnt_inc;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (flush_eff && (cnt_q != '0)) begin
          state_d = HOLD;
          count_d = cnt_q;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // Flush is ignored here; the beat only moves on out_ready.
        if (out_ready) begin
          data_d  = '0;
          count_d = '0;
          cnt_d   = '0;
          state_d = FILL;
          if (fifo_pop) begin
            data_d[D_WIDTH-1:0] = fifo_data;
            if (PACK_N == 1) begin
              state_d = HOLD;
              count_d = CW'(1);
            end else begin
              cnt_d = CW'(1);
            end
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, lane and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_pop_packer
//  Description : Directed self-checking bench for fifo_pop_packer with a small
//                first-word-fall-through FIFO model in front of it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pop_packer;
  import packer_pkg::*;

  localparam int DW = 6;
  localparam int PN = 4;
  localparam int CW = cnt_width(PN);

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    fifo_data;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             flush;
  logic [DW*PN-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_valid;
  logic             out_ready;

  // FIFO model storage: written by the stimulus, read pointer moved on pops.
  logic [DW-1:0] mem [0:63];
  logic [5:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;
  int            underflows = 0;

  int n_assert = 0;
  int n_fail   = 0;
  int pops;
  int bad;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr];

  always #5 clk = ~clk;

  fifo_pop_packer #(
    .D_WIDTH (DW),
    .PACK_N  (PN),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .flush      (flush),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Head is consumed on the edge where the packer pops.
  always @(posedge clk) begin
    if (fifo_pop) begin
      if (fifo_empty) underflows <= underflows + 1;
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state, with words already waiting in the FIFO.
    push(6'h01); push(6'h02); push(6'h03); push(6'h04);
    repeat (2) @(negedge clk);
    #1;
    check("rst_pop",   {63'd0, fifo_pop},  64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data",  64'(out_data),      64'd0);
    check("rst_count", 64'(out_count),     64'd0);

    // Full beat with the consumer ready.
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_pop", {63'd0, fifo_pop}, 64'd1);
      @(negedge clk);
    end
    #1;
    check("full_valid", {63'd0, out_valid}, 64'd1);
    check("full_data",  64'(out_data),      64'({6'h04, 6'h03, 6'h02, 6'h01}));
    check("full_count", 64'(out_count),     64'd4);
    check("full_nopop", {63'd0, fifo_pop},  64'd0);
    @(negedge clk); #1;
    check("full_retired", {63'd0, out_valid}, 64'd0);

    // Backpressure: only four words may be taken while the beat is stuck.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(6'h10 + 6'(i));
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (fifo_pop) pops++;
      @(negedge clk);
    end
    #1;
    check("bp_pops",  64'(pops),           64'd4);
    check("bp_nopop", {63'd0, fifo_pop},   64'd0);
    check("bp_valid", {63'd0, out_valid},  64'd1);
    check("bp_data",  64'(out_data),       64'({6'h13, 6'h12, 6'h11, 6'h10}));
    check("bp_count", 64'(out_count),      64'd4);
    out_ready = 1'b1;
    #1;
    check("bp_retire_pop", {63'd0, fifo_pop}, 64'd1);
    repeat (4) @(negedge clk);
    #1;
    check("bp2_valid", {63'd0, out_valid}, 64'd1);
    check("bp2_data",  64'(out_data),      64'({6'h17, 6'h16, 6'h15, 6'h14}));
    check("bp2_count", 64'(out_count),     64'd4);
    @(negedge clk); #1;
    check("bp2_retired", {63'd0, out_valid}, 64'd0);

    // Flush of a two-word partial beat.
    push(6'h2A); push(6'h15);
    repeat (2) @(negedge clk);
    out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_valid", {63'd0, out_valid}, 64'd1);
    check("flush_count", 64'(out_count),     64'd2);
    check("flush_data",  64'(out_data),      64'({12'h000, 6'h15, 6'h2A}));
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("flush_retired", {63'd0, out_valid}, 64'd0);

    // Flush with nothing collected and nothing to pop is ignored.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_empty_a", {63'd0, out_valid}, 64'd0);
    @(negedge clk); #1;
    check("flush_empty_b", {63'd0, out_valid}, 64'd0);

    // Empty FIFO with random consumer readiness.
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("empty_pop",   {63'd0, fifo_pop},  64'd0);
      check("empty_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end

    // Reset in the middle of a beat discards the partial lanes.
    out_ready = 1'b1;
    #1;
    push(6'h21); push(6'h22); push(6'h23);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_data",  64'(out_data),      64'd0);
    check("mid_rst_count", 64'(out_count),     64'd0);
    push(6'h31); push(6'h32); push(6'h33); push(6'h34);
    repeat (4) @(negedge clk);
    #1;
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_data",  64'(out_data),      64'({6'h34, 6'h33, 6'h32, 6'h31}));
    check("post_rst_count", 64'(out_count),     64'd4);
    @(negedge clk); #1;

    // Single word left alone in the packer.
    push(6'h3F);
`ifdef PACKER_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      check("tmo_wait", {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk); #1;
    check("tmo_valid", {63'd0, out_valid}, 64'd1);
    check("tmo_count", 64'(out_count),     64'd1);
    check("tmo_data",  64'(out_data),      64'h3F);
`else
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (out_valid) bad++;
    end
    check("no_tmo_beat", 64'(bad), 64'd0);
    out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("late_flush_valid", {63'd0, out_valid}, 64'd1);
    check("late_flush_count", 64'(out_count),     64'd1);
    check("late_flush_data",  64'(out_data),      64'h3F);
`endif

    check("fifo_underflow", 64'(underflows), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
